// File: rtl/sdram_w9825g6kh_ctrl_if.sv
// ============================================================================
// Module  : sdram_w9825g6kh_ctrl_if
// Brief   : SDRAM command/address pin bundle plus init-done flag.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface sdram_w9825g6kh_ctrl_if;
  logic        CLK;
  logic        CKE;
  logic        CS_N;
  logic        RAS_N;
  logic        CAS_N;
  logic        WE_N;
  logic [12:0] A;
  logic [1:0]  BS;
  logic [1:0]  DQM;
  logic        INIT_DONE;

  modport master (
    output CLK, CKE, CS_N, RAS_N, CAS_N, WE_N, A, BS, DQM, INIT_DONE
  );

  modport slave (
    input CLK, CKE, CS_N, RAS_N, CAS_N, WE_N, A, BS, DQM, INIT_DONE
  );
endinterface

`default_nettype wire

// File: rtl/sdram_w9825g6kh_ctrl.sv
// ============================================================================
// Module  : sdram_w9825g6kh_ctrl
// Brief   : W9825G6KH power-up init + periodic auto-refresh controller.
//           SIM_FAST_INIT_EN shortens the power-up wait to 20 cycles.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sdram_w9825g6kh_ctrl #(
  parameter int         T_POWERUP_CYC = 20000,
  parameter int         T_RP          = 2,
  parameter int         T_RFC         = 7,
  parameter int         T_MRD         = 2,
  parameter int         INIT_REF_CNT  = 8,
  parameter int         REF_INTERVAL  = 780,
  parameter int         CAS_LATENCY   = 3,
  parameter logic [2:0] BURST_CODE    = 3'b000
) (
  input  logic                           REF_CLK,
  input  logic                           RST,
  sdram_w9825g6kh_ctrl_if.master         sdram,
  inout  wire  [15:0]                    DQ
);

`ifdef SIM_FAST_INIT_EN
  localparam int c_PWR_CYC = 20;
`else
  localparam int c_PWR_CYC = T_POWERUP_CYC;
`endif

  localparam int              c_CNT_MAX       = (c_PWR_CYC > REF_INTERVAL) ? c_PWR_CYC : REF_INTERVAL;
  localparam int              c_CW            = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CW-1:0] c_PWR_LAST      = c_CW'(c_PWR_CYC - 1);
  localparam logic [c_CW-1:0] c_REF_INT       = c_CW'(REF_INTERVAL);
  localparam logic [7:0]      c_RP_W          = 8'(T_RP - 1);
  localparam logic [7:0]      c_RFC_W         = 8'(T_RFC - 1);
  localparam logic [7:0]      c_MRD_W         = 8'(T_MRD - 1);
  localparam logic [7:0]      c_INIT_REF_LAST = 8'(INIT_REF_CNT - 1);
  // Burst write, standard op mode, sequential burst.
  localparam logic [12:0]     c_MODE          = {3'b000, 1'b0, 2'b00, 3'(CAS_LATENCY), 1'b0, BURST_CODE};

  localparam logic [3:0] c_CMD_NOP  = 4'b0111;
  localparam logic [3:0] c_CMD_PRE  = 4'b0010;
  localparam logic [3:0] c_CMD_AREF = 4'b0001;
  localparam logic [3:0] c_CMD_MRS  = 4'b0000;

  typedef enum logic [2:0] {
    S_WAIT_PWR = 3'd0,
    S_PRE      = 3'd1,
    S_AREF     = 3'd2,
    S_MRS      = 3'd3,
    S_IDLE     = 3'd4,
    S_WAIT     = 3'd5
  } state_t;

  state_t          r_state;
  state_t          r_after;
  logic [c_CW-1:0] r_cnt;
  logic [7:0]      r_wait;
  logic [7:0]      r_init_ref;
  logic            r_cke;
  logic [3:0]      r_cmd;
  logic [12:0]     r_a;
  logic [1:0]      r_bs;
  logic [1:0]      r_dqm;
  logic            r_init_done;

  always_ff @(posedge REF_CLK) begin
    if (RST) begin
      r_state     <= S_WAIT_PWR;
      r_after     <= S_WAIT_PWR;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_init_ref  <= '0;
      r_cke       <= 1'b0;
      r_cmd       <= c_CMD_NOP;
      r_a         <= '0;
      r_bs        <= '0;
      r_dqm       <= 2'b11;
      r_init_done <= 1'b0;
    end else begin
      r_cke <= 1'b1;
      r_cmd <= c_CMD_NOP;
      r_a   <= '0;
      r_bs  <= '0;
      case (r_state)
        S_WAIT_PWR: begin
          if (r_cnt == c_PWR_LAST) begin
            r_cnt   <= '0;
            r_state <= S_PRE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PRE: begin
          r_cmd   <= c_CMD_PRE;
          r_a     <= 13'h0400;
          r_wait  <= c_RP_W;
          r_after <= S_AREF;
          r_state <= (T_RP > 1) ? S_WAIT : S_AREF;
        end
        S_AREF: begin
          r_cmd      <= c_CMD_AREF;
          r_init_ref <= r_init_ref + 1'b1;
          r_wait     <= c_RFC_W;
          r_after    <= (r_init_ref == c_INIT_REF_LAST) ? S_MRS : S_AREF;
          if (T_RFC > 1)
            r_state <= S_WAIT;
          else
            r_state <= (r_init_ref == c_INIT_REF_LAST) ? S_MRS : S_AREF;
        end
        S_MRS: begin
          r_cmd   <= c_CMD_MRS;
          r_a     <= c_MODE;
          r_wait  <= c_MRD_W;
          r_after <= S_IDLE;
          r_state <= (T_MRD > 1) ? S_WAIT : S_IDLE;
        end
        S_IDLE: begin
          r_init_done <= 1'b1;
          r_dqm       <= 2'b00;
          // Interval counter restarts on the first idle cycle after each refresh.
          if (r_cnt == c_REF_INT) begin
            r_cmd   <= c_CMD_AREF;
            r_cnt   <= '0;
            r_wait  <= c_RFC_W;
            r_after <= S_IDLE;
            r_state <= (T_RFC > 1) ? S_WAIT : S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          r_wait <= r_wait - 1'b1;
          if (r_wait == 8'd1)
            r_state <= r_after;
        end
        default: r_state <= S_WAIT_PWR;
      endcase
    end
  end

  // SDRAM samples mid-cycle on the inverted clock.
  assign sdram.CLK       = ~REF_CLK;
  assign sdram.CKE       = r_cke;
  assign sdram.CS_N      = r_cmd[3];
  assign sdram.RAS_N     = r_cmd[2];
  assign sdram.CAS_N     = r_cmd[1];
  assign sdram.WE_N      = r_cmd[0];
  assign sdram.A         = r_a;
  assign sdram.BS        = r_bs;
  assign sdram.DQM       = r_dqm;
  assign sdram.INIT_DONE = r_init_done;
  assign DQ              = 16'hzzzz;

endmodule

`default_nettype wire

// File: tb/tb_sdram_w9825g6kh_ctrl.sv
// ============================================================================
// Module  : tb_sdram_w9825g6kh_ctrl
// Brief   : Directed cycle-accurate check of init sequence, refresh and reset.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_sdram_w9825g6kh_ctrl;

`ifdef SIM_FAST_INIT_EN
  localparam int PW = 20;
`else
  localparam int PW = 20000;
`endif

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] MRS  = 4'b0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  wire [15:0] dq;
  logic [3:0] cmd;
  int         n_run  = 0;
  int         n_fail = 0;
  int         stray  = 0;

  sdram_w9825g6kh_ctrl_if bus ();

  sdram_w9825g6kh_ctrl dut (
    .REF_CLK (clk),
    .RST     (rst),
    .sdram   (bus),
    .DQ      (dq)
  );

  always #5 clk = ~clk;

  assign cmd = {bus.CS_N, bus.RAS_N, bus.CAS_N, bus.WE_N};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected command table, cycle 1 = first edge with reset low.
  function automatic logic [3:0] exp_cmd(input int c);
    if (c == PW + 1)                                       return PRE;
    if (c >= PW + 3 && c <= PW + 52 && (c - PW - 3) % 7 == 0) return AREF;
    if (c == PW + 59)                                      return MRS;
    if (c == PW + 841 || c == PW + 841 + 7 + 780)          return AREF;
    return NOP;
  endfunction

  function automatic logic [12:0] exp_a(input int c);
    if (c == PW + 1)  return 13'h0400;
    if (c == PW + 59) return 13'h0030;
    return 13'h0000;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_cke"},  32'(bus.CKE),       32'd0);
    check({tag, "_cmd"},  32'(cmd),           32'(NOP));
    check({tag, "_a"},    32'(bus.A),         32'd0);
    check({tag, "_bs"},   32'(bus.BS),        32'd0);
    check({tag, "_dqm"},  32'(bus.DQM),       32'd3);
    check({tag, "_done"}, 32'(bus.INIT_DONE), 32'd0);
  endtask

  task automatic run_cycles(input int last);
    for (int c = 1; c <= last; c++) begin
      tick();
      if (exp_cmd(c) != NOP) begin
        check($sformatf("cmd@%0d", c), 32'(cmd), 32'(exp_cmd(c)));
        check($sformatf("a@%0d", c), 32'(bus.A), 32'(exp_a(c)));
      end else if (cmd != NOP || bus.A != 13'h0) begin
        stray++;
      end
      if (bus.CKE !== 1'b1) stray++;
      if (bus.BS !== 2'b00) stray++;
      if (bus.INIT_DONE !== (c >= PW + 61)) stray++;
      if (c == PW + 60) begin
        check("dqm_pre_done", 32'(bus.DQM), 32'd3);
        check("done_pre", 32'(bus.INIT_DONE), 32'd0);
      end
      if (c == PW + 61) begin
        check("done_rise", 32'(bus.INIT_DONE), 32'd1);
        check("dqm_idle", 32'(bus.DQM), 32'd0);
      end
      if (c == PW + 840) check("dqm_idle_late", 32'(bus.DQM), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (5) tick();
    check_reset("rst");
    check("sdram_clk_inv", 32'(bus.CLK), 32'd0);

    rst = 1'b0;
    stray = 0;
    run_cycles(PW + 1700);
    check("stray_run1", 32'(stray), 32'd0);

    // Restart cleanly, then hit reset during the init refresh train.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stray = 0;
    run_cycles(PW + 19);
    rst = 1'b1;
    tick();
    check_reset("midrst");
    rst = 1'b0;
    run_cycles(PW + 21);
    check("stray_run2", 32'(stray), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
